// File: rtl/link_tx.sv
// link_tx: moves flits from a source FIFO onto a 4-phase req/ack link.
// Each flit is popped in IDLE, presented with req high in REQ, and the
// handshake completes in REL once the receiver drops ack.
// Optional feature macro: LINK_TX_COUNT_EN enables the completed-flit counter
// on tx_count; without it tx_count is tied to zero and no counter exists.
module link_tx #(
    parameter int ID   = -1,
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fifo_empty,
    input  logic [SIZE-1:0] fifo_item,
    output logic            fifo_read,
    output logic [SIZE-1:0] data,
    output logic            req,
    input  logic            ack,
    output logic            busy,
    output logic [15:0]     tx_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // The instance identifier has no effect on the logic; only reject nonsense values.
    if (ID < -1) begin : g_id_check
        $error("link_tx: ID must be -1 or a non-negative instance number");
    end

    // Next-state decode; a pop is only legal from IDLE with data available and ack low.
    always_comb begin
        next_state = state;
        fifo_read  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !ack) begin
                    fifo_read  = 1'b1;
                    next_state = REQ;
                end
            end
            REQ: begin
                if (ack) begin
                    next_state = REL;
                end
            end
            REL: begin
                if (!ack) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register; reset abandons any flit in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request is high exactly while the machine sits in REQ, registered for a clean link.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req <= 1'b0;
        end else begin
            req <= (next_state == REQ);
        end
    end

    // Flit register captures the FIFO head on the pop edge and otherwise holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data <= '0;
        end else if (fifo_read) begin
            data <= fifo_item;
        end
    end

    assign busy = (state != IDLE);

`ifdef LINK_TX_COUNT_EN
    logic        done;
    logic [15:0] count_q;

    assign done = (state == REL) && !ack;

    // Completed-flit counter, bumped on every REL to IDLE return and wrapping naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= 16'h0000;
        end else if (done) begin
            count_q <= count_q + 16'h0001;
        end
    end

    assign tx_count = count_q;
`else
    assign tx_count = 16'h0000;
`endif

endmodule

// File: tb/tb_link_tx.sv
// tb_link_tx: directed bench for link_tx with a small queue standing in for
// the source FIFO and the receiver's ack driven step by step.
// Honours LINK_TX_COUNT_EN the same way as the design.
`timescale 1ns/1ps
module tb_link_tx;

    logic        clk;
    logic        reset;
    logic        fifo_empty;
    logic [7:0]  fifo_item;
    logic        fifo_read;
    logic [7:0]  data;
    logic        req;
    logic        ack;
    logic        busy;
    logic [15:0] tx_count;

    logic [7:0]  fifo_q[$];
    int          compared;
    int          mismatched;
    int          pops;
    int          exp_pops;
    logic [15:0] exp_count;

`ifdef LINK_TX_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    link_tx #(.ID(3), .SIZE(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .fifo_empty(fifo_empty),
        .fifo_item (fifo_item),
        .fifo_read (fifo_read),
        .data      (data),
        .req       (req),
        .ack       (ack),
        .busy      (busy),
        .tx_count  (tx_count)
    );

    // Free-running clock, 20 ns period.
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    function automatic logic [15:0] exp_tx();
        return CNT_EN ? exp_count : 16'h0000;
    endfunction

    task automatic refresh_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_item  = fifo_empty ? 8'h00 : fifo_q[0];
    endtask

    task automatic push_item(input logic [7:0] item);
        fifo_q.push_back(item);
        refresh_fifo();
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample the pop strobe mid-cycle, then apply the pop after the edge.
    task automatic apply_stimulus();
        logic pop;
        @(negedge clk);
        pop = fifo_read;
        @(posedge clk);
        #1;
        if (pop) begin
            void'(fifo_q.pop_front());
            pops++;
            refresh_fifo();
            #1;
        end
    endtask

    // Full handshake with a receiver that answers one cycle after each req change.
    task automatic send_flit(input string tag, input logic [7:0] item);
        check_output({tag, "_pop_strobe"}, fifo_read, 1);
        apply_stimulus();
        exp_pops++;
        check_output({tag, "_req_up"}, req, 1);
        check_output({tag, "_data"}, data, item);
        check_output({tag, "_busy_req"}, busy, 1);
        check_output({tag, "_no_pop_req"}, fifo_read, 0);
        ack = 1'b1;
        #1;
        apply_stimulus();
        check_output({tag, "_req_down"}, req, 0);
        check_output({tag, "_busy_rel"}, busy, 1);
        ack = 1'b0;
        #1;
        apply_stimulus();
        exp_count = exp_count + 16'h0001;
        check_output({tag, "_idle"}, busy, 0);
        check_output({tag, "_data_hold"}, data, item);
        check_output({tag, "_count"}, tx_count, exp_tx());
        check_output({tag, "_pops"}, pops, exp_pops);
    endtask

    initial begin
        logic [7:0] seq [3];
        compared   = 0;
        mismatched = 0;
        pops       = 0;
        exp_pops   = 0;
        exp_count  = 16'h0000;
        reset      = 1'b0;
        ack        = 1'b0;
        refresh_fifo();
        #1;

        // Reset state
        check_output("rst_req", req, 0);
        check_output("rst_data", data, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_count", tx_count, 0);
        check_output("rst_read_empty", fifo_read, 0);
        apply_stimulus();
        apply_stimulus();
        reset = 1'b1;
        #1;

        // Empty FIFO: stay idle
        apply_stimulus();
        check_output("empty_idle", busy, 0);
        check_output("empty_req", req, 0);

        // Single flit
        push_item(8'hA5);
        send_flit("single", 8'hA5);

        // Back-to-back with immediate ack: a new pop every third cycle
        seq[0] = 8'h01;
        seq[1] = 8'h02;
        seq[2] = 8'h03;
        for (int k = 0; k < 3; k++) begin
            push_item(seq[k]);
        end
        for (int k = 0; k < 3; k++) begin
            send_flit("b2b", seq[k]);
        end
        check_output("b2b_empty", fifo_empty, 1);
        check_output("b2b_no_read", fifo_read, 0);

        // Slow receiver with a second item waiting
        push_item(8'h5A);
        push_item(8'h77);
        apply_stimulus();
        exp_pops++;
        for (int k = 0; k < 10; k++) begin
            check_output("slow_req_hold", req, 1);
            check_output("slow_data_hold", data, 8'h5A);
            check_output("slow_no_pop_req", fifo_read, 0);
            apply_stimulus();
        end
        ack = 1'b1;
        #1;
        apply_stimulus();
        for (int k = 0; k < 5; k++) begin
            check_output("slow_rel_req", req, 0);
            check_output("slow_rel_busy", busy, 1);
            check_output("slow_no_pop_rel", fifo_read, 0);
            apply_stimulus();
        end
        ack = 1'b0;
        #1;
        apply_stimulus();
        exp_count = exp_count + 16'h0001;
        check_output("slow_idle", busy, 0);
        check_output("slow_count", tx_count, exp_tx());
        check_output("slow_pops", pops, exp_pops);
        send_flit("after_slow", 8'h77);

        // Reset while in REQ abandons 3C; 99 goes next
        push_item(8'h3C);
        push_item(8'h99);
        apply_stimulus();
        exp_pops++;
        check_output("mid_data_before", data, 8'h3C);
        #2;
        reset = 1'b0;
        #1;
        exp_count = 16'h0000;
        check_output("mid_req", req, 0);
        check_output("mid_data", data, 0);
        check_output("mid_busy", busy, 0);
        check_output("mid_count", tx_count, 0);
        #1;
        reset = 1'b1;
        #1;
        send_flit("after_rst", 8'h99);

        // Stale ack across reset release
        ack   = 1'b1;
        reset = 1'b0;
        #1;
        push_item(8'hC3);
        reset = 1'b1;
        #1;
        exp_count = 16'h0000;
        check_output("stale_no_read", fifo_read, 0);
        apply_stimulus();
        apply_stimulus();
        check_output("stale_idle", busy, 0);
        check_output("stale_no_read2", fifo_read, 0);
        check_output("stale_data", data, 0);
        ack = 1'b0;
        #1;
        send_flit("stale", 8'hC3);

        // Counter wrap
`ifdef LINK_TX_COUNT_EN
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        exp_count = 16'hFFFF;
        #1;
        check_output("wrap_preload", tx_count, 16'hFFFF);
`endif
        push_item(8'h42);
        send_flit("wrap", 8'h42);
        check_output("wrap_final", tx_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
